// File: rtl/agc_ctrl.sv
// agc_ctrl: window-peak automatic gain control for the I/Q shift/round stage.
// Measures the peak magnitude over each window of accepted samples, then steps
// the left-shift adjust word down on clip or overload and up on low level.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | loop open; adjust tracks clamped adj_init, accumulators clear
//   S_ACCUM  | collecting window samples (peak, clip, count) on nd
//   S_DECIDE | one cycle: apply gain step, publish window results
//   S_SETTLE | ignore samples while the new shift propagates downstream
module agc_ctrl #(
  parameter int DATA_WIDTH = 20,
  parameter int ADJ_WIDTH  = 11,
  parameter int ADJ_MAX    = 16,
  parameter int WIN_LOG2   = 10,
  parameter int SETTLE     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [ADJ_WIDTH-1:0]         adj_init,
  input  logic [DATA_WIDTH-2:0]        hi_thresh,
  input  logic [DATA_WIDTH-2:0]        lo_thresh,
  input  logic signed [DATA_WIDTH-1:0] din_i,
  input  logic signed [DATA_WIDTH-1:0] din_q,
  input  logic                         nd,
  output logic [ADJ_WIDTH-1:0]         adjust,
  output logic                         adj_valid,
  output logic [DATA_WIDTH-2:0]        peak_out,
  output logic                         peak_valid,
  output logic                         clip_flag
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  localparam int MW = DATA_WIDTH - 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [MW-1:0]                MAG_MAX     = '1;
  localparam logic signed [DATA_WIDTH-1:0] POS_FS      = {1'b0, {MW{1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] NEG_FS      = {1'b1, {MW{1'b0}}};
  localparam logic [ADJ_WIDTH-1:0]         ADJ_MAX_W   = ADJ_WIDTH'(ADJ_MAX);
  localparam logic [ADJ_WIDTH-1:0]         ADJ_ONE     = ADJ_WIDTH'(1);
  localparam logic [ADJ_WIDTH-1:0]         ADJ_TWO     = ADJ_WIDTH'(2);
  localparam logic [WIN_LOG2-1:0]          WIN_LAST    = '1;
  localparam logic [SW-1:0]                SETTLE_LOAD = SW'(SETTLE - 1);

  logic [1:0]           state;
  logic [WIN_LOG2-1:0]  win_cnt;
  logic [MW-1:0]        peak_acc;
  logic                 clip_acc;
  logic [SW-1:0]        settle_cnt;

  logic [MW-1:0]        mag_i;
  logic [MW-1:0]        mag_q;
  logic [MW-1:0]        mag;
  logic                 clip_smp;
  logic [ADJ_WIDTH-1:0] adj_cfg;
  logic [ADJ_WIDTH-1:0] adj_next;

  // Most-negative input saturates to full scale instead of wrapping to zero.
  function automatic logic [MW-1:0] abs_sat(input logic signed [DATA_WIDTH-1:0] x);
    if (x == NEG_FS)
      abs_sat = MAG_MAX;
    else if (x[DATA_WIDTH-1])
      abs_sat = MW'(-x);
    else
      abs_sat = MW'(x);
  endfunction

  // Sample magnitude/clip detection, clamped start value and next gain step.
  always_comb begin
    mag_i    = abs_sat(din_i);
    mag_q    = abs_sat(din_q);
    mag      = (mag_i > mag_q) ? mag_i : mag_q;
    clip_smp = (din_i == POS_FS) || (din_i == NEG_FS) ||
               (din_q == POS_FS) || (din_q == NEG_FS);
    adj_cfg  = (adj_init > ADJ_MAX_W) ? ADJ_MAX_W : adj_init;
    adj_next = adjust;
    if (clip_acc)
      adj_next = (adjust >= ADJ_TWO) ? adjust - ADJ_TWO : '0;
    else if (peak_acc > hi_thresh)
      adj_next = (adjust >= ADJ_ONE) ? adjust - ADJ_ONE : '0;
    else if (peak_acc < lo_thresh)
      adj_next = (adjust < ADJ_MAX_W) ? adjust + ADJ_ONE : ADJ_MAX_W;
  end

  // Control FSM, window accumulators and registered outputs.
  always_ff @(posedge clk) begin
    adj_valid  <= 1'b0;
    peak_valid <= 1'b0;
    if (rst) begin
      state      <= S_IDLE;
      adjust     <= '0;
      peak_out   <= '0;
      clip_flag  <= 1'b0;
      win_cnt    <= '0;
      peak_acc   <= '0;
      clip_acc   <= 1'b0;
      settle_cnt <= '0;
    end else if (state != S_IDLE && !enable) begin
      // Opening the loop discards any partial window.
      state    <= S_IDLE;
      win_cnt  <= '0;
      peak_acc <= '0;
      clip_acc <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          adjust   <= adj_cfg;
          win_cnt  <= '0;
          peak_acc <= '0;
          clip_acc <= 1'b0;
          if (enable) state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (nd) begin
            win_cnt  <= win_cnt + 1'b1;
            peak_acc <= (mag > peak_acc) ? mag : peak_acc;
            clip_acc <= clip_acc | clip_smp;
            if (win_cnt == WIN_LAST) state <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          adjust     <= adj_next;
          adj_valid  <= (adj_next != adjust);
          peak_out   <= peak_acc;
          peak_valid <= 1'b1;
          clip_flag  <= clip_acc;
          win_cnt    <= '0;
          peak_acc   <= '0;
          clip_acc   <= 1'b0;
          settle_cnt <= SETTLE_LOAD;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == '0) state <= S_ACCUM;
          else settle_cnt <= settle_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_agc_ctrl.sv
// Testbench for agc_ctrl: window table plus hand-written sequences, with a
// scoreboard of expected window results checked when peak_valid fires.
module tb_agc_ctrl;

  localparam int DW = 20;
  localparam int AW = 11;

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic [AW-1:0]        adj_init;
  logic [DW-2:0]        hi_thresh;
  logic [DW-2:0]        lo_thresh;
  logic signed [DW-1:0] din_i;
  logic signed [DW-1:0] din_q;
  logic                 nd;
  logic [AW-1:0]        adjust;
  logic                 adj_valid;
  logic [DW-2:0]        peak_out;
  logic                 peak_valid;
  logic                 clip_flag;

  agc_ctrl #(
    .DATA_WIDTH(DW), .ADJ_WIDTH(AW), .ADJ_MAX(16), .WIN_LOG2(2), .SETTLE(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .adj_init(adj_init),
    .hi_thresh(hi_thresh), .lo_thresh(lo_thresh),
    .din_i(din_i), .din_q(din_q), .nd(nd),
    .adjust(adjust), .adj_valid(adj_valid),
    .peak_out(peak_out), .peak_valid(peak_valid), .clip_flag(clip_flag)
  );

  typedef struct {
    int i0;
    int ir;
    int q;
    int hi;
    int lo;
    int peak;
    int clip;
    int adj;
    int av;
  } win_t;

  typedef struct {
    int peak;
    int clip;
    int adj;
    int av;
    int stamp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Scoreboard side: compare each published window against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (adj_valid && !peak_valid) begin
        checks++;
        errors++;
        $display("FAIL adj_valid_alone: adj_valid=1 without peak_valid (cycle %0d)", cyc);
      end
      if (peak_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_peak_valid: got pulse, peak_out=%0d expected none (cycle %0d)",
                   peak_out, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("window_latency", cyc, e.stamp);
          check("peak_out", int'(peak_out), e.peak);
          check("clip_flag", int'(clip_flag), e.clip);
          check("adjust", int'(adjust), e.adj);
          check("adj_valid", int'(adj_valid), e.av);
        end
      end
    end
  end

  // Drives one full window; the expectation is pushed with the 4th sample.
  task automatic run_window(input win_t w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      hi_thresh = 19'(w.hi);
      lo_thresh = 19'(w.lo);
      din_i     = 20'((k == 0) ? w.i0 : w.ir);
      din_q     = 20'(w.q);
      nd        = 1'b1;
      if (k == 3) sb.push_back('{w.peak, w.clip, w.adj, w.av, cyc + 2});
    end
  endtask

  task automatic idle_gap(input int n);
    @(negedge clk);
    nd = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_pair(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      din_i = 20'(i);
      din_q = '0;
      nd    = 1'b1;
    end
  endtask

  win_t tbl[14];
  win_t w_lo;

  initial begin
    //           i0       ir      q        hi      lo    peak   clip adj av
    tbl[0]  = '{100,     100,    -50,     200000, 1000, 100,    0, 6, 1};
    tbl[1]  = '{-300000, -300000, 0,      200000, 1000, 300000, 0, 5, 1};
    tbl[2]  = '{-524288, 10,     0,       200000, 1000, 524287, 1, 3, 1};
    tbl[3]  = '{524287,  0,      0,       200000, 1000, 524287, 1, 1, 1};
    tbl[4]  = '{-524288, 10,     0,       200000, 1000, 524287, 1, 0, 1};
    tbl[5]  = '{300000,  300000, 0,       200000, 1000, 300000, 0, 0, 0};
    tbl[6]  = '{5000,    5000,   -7000,   200000, 1000, 7000,   0, 0, 0};
    tbl[7]  = '{10,      10,     20,      200000, 1000, 20,     0, 1, 1};
    tbl[8]  = '{3000,    3000,   0,       100,    5000, 3000,   0, 0, 1};
    tbl[9]  = '{50,      50,     0,       100,    5000, 50,     0, 1, 1};
    tbl[10] = '{200000,  200000, 0,       200000, 1000, 200000, 0, 1, 0};
    tbl[11] = '{1000,    1000,   0,       200000, 1000, 1000,   0, 1, 0};
    tbl[12] = '{0,       0,      -524288, 200000, 1000, 524287, 1, 0, 1};
    tbl[13] = '{10,      10,     0,       200000, 1000, 10,     0, 1, 1};

    rst       = 1'b1;
    enable    = 1'b0;
    adj_init  = 11'd5;
    hi_thresh = 19'd200000;
    lo_thresh = 19'd1000;
    din_i     = '0;
    din_q     = '0;
    nd        = 1'b0;

    // Reset values, then clamped reload of adj_init while idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_adjust", int'(adjust), 0);
    check("rst_adj_valid", int'(adj_valid), 0);
    check("rst_peak_out", int'(peak_out), 0);
    check("rst_peak_valid", int'(peak_valid), 0);
    check("rst_clip_flag", int'(clip_flag), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_adjust", int'(adjust), 5);
    adj_init = 11'd40;
    @(negedge clk);
    check("clamp_adjust", int'(adjust), 16);
    adj_init = 11'd5;
    @(negedge clk);
    check("reload_adjust", int'(adjust), 5);
    enable = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 14; n++) begin
      run_window(tbl[n]);
      idle_gap(6);
    end

    // Samples during DECIDE and all SETTLE cycles must be ignored.
    w_lo = '{10, 10, 0, 200000, 1000, 10, 0, 2, 1};
    run_window(w_lo);
    drive_pair(500000, 5);
    w_lo = '{10, 10, 0, 200000, 1000, 10, 0, 3, 1};
    run_window(w_lo);
    idle_gap(6);

    // Enable dropped mid-window: partial window discarded, adjust reloads.
    drive_pair(300000, 2);
    @(negedge clk);
    nd     = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("enable_reload_adjust", int'(adjust), 5);
    w_lo = '{100, 100, 0, 200000, 1000, 100, 0, 6, 1};
    run_window(w_lo);
    idle_gap(6);

    // At ADJ_MAX a low window holds gain but still publishes the peak.
    enable   = 1'b0;
    adj_init = 11'd40;
    repeat (2) @(negedge clk);
    check("max_reload_adjust", int'(adjust), 16);
    enable = 1'b1;
    w_lo = '{10, 10, 0, 200000, 1000, 10, 0, 16, 0};
    run_window(w_lo);
    idle_gap(6);

    // Reset mid-window clears everything; enable held high restarts cleanly.
    adj_init = 11'd5;
    drive_pair(300000, 2);
    @(negedge clk);
    nd  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_adjust", int'(adjust), 0);
    check("midrst_peak_out", int'(peak_out), 0);
    check("midrst_clip_flag", int'(clip_flag), 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_reload_adjust", int'(adjust), 5);
    w_lo = '{100, 100, 0, 200000, 1000, 100, 0, 6, 1};
    run_window(w_lo);
    idle_gap(10);

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
